// File: rtl/down_fir_mac.sv
// Serial-MAC decimate-by-2 FIR engine fed by the down_rom coefficient ROM.
// Latency: out_valid strobes N+4 cycles after the accept that completes a sample pair (N = 47 or 126).
// Backpressure: none on the output side; in_ready drops only while history is cleared, and starts while busy are dropped and flagged in overrun.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous pulse: abort, zero history, clear overrun
//   use_882             rate select (47 taps when 1, 126 taps when 0), latched at each start
//   in_data/in_valid    input PCM sample and its valid; in_ready is low during history clear
//   rom_addr/rom_sel    tap index and latched rate select driven to down_rom
//   rom_tap             combinational tap returned by down_rom
//   out_data/out_valid  decimated sample and its one-cycle strobe
//   overrun             sticky flag: a start arrived while a computation was in flight
//
// Build option: define DOWN_FIR_SAT_EN for round-half-up plus saturation on the output;
// without it the output is acc >>> COEF_FRAC truncated, with the low DW bits taken as-is.
module down_fir_mac #(
  parameter int DW        = 24,
  parameter int CW        = 32,
  parameter int AW        = 64,
  parameter int COEF_FRAC = 30,
  parameter int N882      = 47,
  parameter int N441      = 126,
  parameter int HIST_LOG2 = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          use_882,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [6:0]    rom_addr,
  output logic          rom_sel,
  input  logic [CW-1:0] rom_tap,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          overrun
);

  localparam int HD = 1 << HIST_LOG2;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                 state;
  logic                   phase;
  logic [HIST_LOG2-1:0]   wr_ptr;
  logic [HIST_LOG2-1:0]   base;
  logic [HIST_LOG2-1:0]   clr_cnt;
  logic [6:0]             ntaps;
  logic                   drain_cnt;

  logic                   accept;
  logic                   start;

  // clear takes priority over a sample presented in the same cycle
  assign accept = in_valid & in_ready & ~clear;
  assign start  = accept & phase;

  // ---------------------------------------------------------------------------
  // History RAM: single write port (clear sweep or sample), one registered read
  // ---------------------------------------------------------------------------
  logic [DW-1:0]        hist [HD];
  logic                 hist_we;
  logic [HIST_LOG2-1:0] hist_waddr;
  logic [DW-1:0]        hist_wdata;
  logic [HIST_LOG2-1:0] rd_addr;

  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = wr_ptr;
    hist_wdata = in_data;
    if (state == S_CLEAR) begin
      hist_we    = 1'b1;
      hist_waddr = clr_cnt;
      hist_wdata = '0;
    end else if (accept) begin
      hist_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hist_we) hist[hist_waddr] <= hist_wdata;
  end

  // Reads walk backwards from the newest sample of the pair; base is frozen for the
  // whole computation, so samples written meanwhile land ahead of the taps in use.
  assign rd_addr = base - rom_addr[HIST_LOG2-1:0];

  // ---------------------------------------------------------------------------
  // MAC pipeline: read/tap register -> product register -> accumulate
  // ---------------------------------------------------------------------------
  logic [DW-1:0]        x_q;
  logic [CW-1:0]        tap_q;
  logic                 rd_vld;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] t_ext;
  logic signed [AW-1:0] prod;
  logic                 prod_vld;
  logic signed [AW-1:0] acc;

  assign x_ext = AW'($signed(x_q));
  assign t_ext = AW'($signed(tap_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      tap_q    <= '0;
      rd_vld   <= 1'b0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      x_q      <= hist[rd_addr];
      tap_q    <= rom_tap;
      rd_vld   <= (state == S_RUN) && !clear;
      prod     <= x_ext * t_ext;
      prod_vld <= rd_vld && !clear;
      if (start && (state == S_IDLE) && !clear) begin
        acc <= '0;
      end else if (prod_vld) begin
        acc <= acc + prod;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output scaling
  // ---------------------------------------------------------------------------
  logic [DW-1:0] result;

`ifdef DOWN_FIR_SAT_EN
  localparam logic signed [AW-1:0] RND =
    {{(AW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] acc_shr;

  assign acc_shr = (acc + RND) >>> COEF_FRAC;

  always_comb begin
    if (acc_shr > SAT_MAX) begin
      result = SAT_MAX[DW-1:0];
    end else if (acc_shr < SAT_MIN) begin
      result = SAT_MIN[DW-1:0];
    end else begin
      result = acc_shr[DW-1:0];
    end
  end
`else
  // Arithmetic shift then keep DW bits is the same as this direct slice.
  assign result = acc[COEF_FRAC +: DW];
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      phase     <= 1'b0;
      wr_ptr    <= '0;
      base      <= '0;
      clr_cnt   <= '0;
      ntaps     <= '0;
      drain_cnt <= 1'b0;
      in_ready  <= 1'b0;
      rom_addr  <= '0;
      rom_sel   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      phase     <= 1'b0;
      wr_ptr    <= '0;
      overrun   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= ~phase;
      end

      // A start outside IDLE is lost; the sample itself was still stored above.
      if (start && (state != S_IDLE)) overrun <= 1'b1;

      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (start) begin
            base     <= wr_ptr;
            rom_sel  <= use_882;
            ntaps    <= use_882 ? 7'(N882) : 7'(N441);
            rom_addr <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (rom_addr == ntaps - 7'd1) begin
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            rom_addr <= rom_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // two cycles: last product registered, then last accumulate
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_OUT;
        end
        S_OUT: begin
          out_data  <= result;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule
